// File: rtl/int_countdn_regs_pkg.sv
// Shared word geometry, interrupt-ack bit indices and word-timing payload for the countdown registers.
package int_countdn_regs_pkg;

    localparam int unsigned LVDA_WORD_W = 26;
    localparam int unsigned LVDA_POS_W  = 5;

    localparam int unsigned ACK_C2 = 0;
    localparam int unsigned ACK_C3 = 1;

    // Per-cycle word timing broadcast from the shared bit counter to each register.
    typedef struct packed {
        logic shift;  // a bit time strobe is present
        logic bit0;   // this strobe is bit 0 of a word
        logic eow;    // this strobe is bit WIDTH-1 of a word
    } word_tick_t;

endpackage

// File: rtl/int_countdn_regs_serial_cd_reg.sv
// One serial countdown register: recirculating shift register, pending parallel load,
// run/zero tracking and the latched zero interrupt.
module int_countdn_regs_serial_cd_reg
    import int_countdn_regs_pkg::*;
#(
    parameter int unsigned WIDTH = LVDA_WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  word_tick_t       tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             en,
    input  logic             rd,
    input  logic             ack,
    output logic             ser,
    output logic             ser_n,
    output logic [WIDTH-1:0] val,
    output logic             int_flag
);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] hold_q;
    logic             pend_q, pend_d;
    logic             run_q, run_d;
    logic             nz_q, nz_d;
    logic             int_q, int_d;
    logic             ser_n_q;
    logic             shift_in;
    logic             nz_word;
    logic             apply_load;
    logic             zero_hit;

    // Next-state: shift/recirculate, apply pending load at word end, detect a counted-out word.
    always_comb begin
        sr_d       = sr_q;
        pend_d     = pend_q;
        run_d      = run_q;
        nz_d       = nz_q;
        int_d      = int_q;
        shift_in   = (en && run_q) ? rd : sr_q[0];
        nz_word    = (tick.bit0 ? 1'b0 : nz_q) | shift_in;
        apply_load = tick.eow && pend_q;
        zero_hit   = tick.eow && !pend_q && run_q && en && !nz_word;

        if (tick.shift) begin
            sr_d = {shift_in, sr_q[WIDTH-1:1]};
            nz_d = nz_word;
        end
        if (apply_load) begin
            sr_d   = hold_q;
            run_d  = 1'b1;
            pend_d = 1'b0;
        end
        if (zero_hit) begin
            run_d = 1'b0;
        end
        if (load) begin
            pend_d = 1'b1;
        end
        if (ack) begin
            int_d = 1'b0;
        end
        if (zero_hit) begin
            int_d = 1'b1;
        end
    end

    // State registers; the complement output is its own flop so both serial lines are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q    <= '0;
            hold_q  <= '0;
            pend_q  <= 1'b0;
            run_q   <= 1'b0;
            nz_q    <= 1'b0;
            int_q   <= 1'b0;
            ser_n_q <= 1'b1;
        end else begin
            sr_q    <= sr_d;
            pend_q  <= pend_d;
            run_q   <= run_d;
            nz_q    <= nz_d;
            int_q   <= int_d;
            ser_n_q <= ~sr_d[0];
            if (load) begin
                hold_q <= load_data;
            end
        end
    end

    assign ser      = sr_q[0];
    assign ser_n    = ser_n_q;
    assign val      = sr_q;
    assign int_flag = int_q;

endmodule

// File: rtl/int_countdn_regs.sv
// LVDA interrupt countdown registers C2/C3: shared bit-position counter plus two serial registers.
module int_countdn_regs
    import int_countdn_regs_pkg::*;
#(
    parameter int unsigned WIDTH = LVDA_WORD_W,
    parameter int unsigned CNT_W = LVDA_POS_W
) (
    input  logic             SIM_CLK,
    input  logic             SIM_RST,
    input  logic             BIT_STB,
    input  logic             WORD_SYNC,
    input  logic             LOAD_C2,
    input  logic             LOAD_C3,
    input  logic [WIDTH-1:0] LOAD_DATA,
    input  logic             C2_EN,
    input  logic             C3_EN,
    input  logic             C2RD,
    input  logic             C3RD,
    input  logic [1:0]       INT_ACK,
    output logic             C2R,
    output logic             C2RN,
    output logic             C3R,
    output logic             C3RN,
    output logic [CNT_W-1:0] BIT_POS,
    output logic [WIDTH-1:0] C2_VAL,
    output logic [WIDTH-1:0] C3_VAL,
    output logic             INT_C2,
    output logic             INT_C3
);

    logic [CNT_W-1:0] pos_q;
    word_tick_t       tick;

    // End-of-word decode; WORD_SYNC makes the current strobe bit 0 regardless of the counter.
    always_comb begin
        tick       = '0;
        tick.shift = BIT_STB;
        tick.bit0  = BIT_STB && (WORD_SYNC || (pos_q == '0));
        tick.eow   = BIT_STB && !WORD_SYNC && (pos_q == CNT_W'(WIDTH - 1));
    end

    // Bit-position counter advanced by each strobe.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            pos_q <= '0;
        end else if (BIT_STB) begin
            if (WORD_SYNC) begin
                pos_q <= CNT_W'(1);
            end else if (tick.eow) begin
                pos_q <= '0;
            end else begin
                pos_q <= pos_q + CNT_W'(1);
            end
        end
    end

    assign BIT_POS = pos_q;

    int_countdn_regs_serial_cd_reg #(.WIDTH(WIDTH)) u_c2 (
        .clk       (SIM_CLK),
        .rst       (SIM_RST),
        .tick      (tick),
        .load      (LOAD_C2),
        .load_data (LOAD_DATA),
        .en        (C2_EN),
        .rd        (C2RD),
        .ack       (INT_ACK[ACK_C2]),
        .ser       (C2R),
        .ser_n     (C2RN),
        .val       (C2_VAL),
        .int_flag  (INT_C2)
    );

    int_countdn_regs_serial_cd_reg #(.WIDTH(WIDTH)) u_c3 (
        .clk       (SIM_CLK),
        .rst       (SIM_RST),
        .tick      (tick),
        .load      (LOAD_C3),
        .load_data (LOAD_DATA),
        .en        (C3_EN),
        .rd        (C3RD),
        .ack       (INT_ACK[ACK_C3]),
        .ser       (C3R),
        .ser_n     (C3RN),
        .val       (C3_VAL),
        .int_flag  (INT_C3)
    );

endmodule

// File: tb/tb_int_countdn_regs.sv
// Bench for int_countdn_regs: directed scenarios plus random traffic against a word-level model.
module tb_int_countdn_regs;

    localparam int unsigned W    = 26;
    localparam int unsigned MASK = (32'd1 << W) - 32'd1;

    logic          clk;
    logic          rst;
    logic          bit_stb;
    logic          word_sync;
    logic          load_c2;
    logic          load_c3;
    logic [W-1:0]  load_data;
    logic          c2_en;
    logic          c3_en;
    logic          c2rd;
    logic          c3rd;
    logic [1:0]    int_ack;
    logic          c2r, c2rn, c3r, c3rn;
    logic [4:0]    bit_pos;
    logic [W-1:0]  c2_val, c3_val;
    logic          int_c2, int_c3;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: register contents as integers, word position, per-register flags.
    int unsigned m_val[2];
    int unsigned m_hold[2];
    int unsigned m_ones[2];
    int unsigned m_dec[2];
    bit          m_pend[2];
    bit          m_run[2];
    bit          m_int[2];
    int unsigned m_pos;
    // Returned-stream source per register: 0 loopback, 1 decremented word, 2 random bits.
    int unsigned rd_mode[2];

    int_countdn_regs dut (
        .SIM_CLK   (clk),
        .SIM_RST   (rst),
        .BIT_STB   (bit_stb),
        .WORD_SYNC (word_sync),
        .LOAD_C2   (load_c2),
        .LOAD_C3   (load_c3),
        .LOAD_DATA (load_data),
        .C2_EN     (c2_en),
        .C3_EN     (c3_en),
        .C2RD      (c2rd),
        .C3RD      (c3rd),
        .INT_ACK   (int_ack),
        .C2R       (c2r),
        .C2RN      (c2rn),
        .C3R       (c3r),
        .C3RN      (c3rn),
        .BIT_POS   (bit_pos),
        .C2_VAL    (c2_val),
        .C3_VAL    (c3_val),
        .INT_C2    (int_c2),
        .INT_C3    (int_c3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int x = 0; x < 2; x++) begin
            m_val[x]  = 0;
            m_hold[x] = 0;
            m_ones[x] = 0;
            m_dec[x]  = 0;
            m_pend[x] = 1'b0;
            m_run[x]  = 1'b0;
            m_int[x]  = 1'b0;
        end
        m_pos = 0;
    endtask

    task automatic compare_outputs();
        check_val("c2r",     32'(c2r),     m_val[0] & 1);
        check_val("c2rn",    32'(c2rn),    (m_val[0] & 1) ^ 1);
        check_val("c3r",     32'(c3r),     m_val[1] & 1);
        check_val("c3rn",    32'(c3rn),    (m_val[1] & 1) ^ 1);
        check_val("bit_pos", 32'(bit_pos), m_pos);
        check_val("int_c2",  32'(int_c2),  32'(m_int[0]));
        check_val("int_c3",  32'(int_c3),  32'(m_int[1]));
        if (m_pos == 0) begin
            check_val("c2_val", 32'(c2_val), m_val[0]);
            check_val("c3_val", 32'(c3_val), m_val[1]);
        end
    endtask

    // One clock: derive returned bits, advance the model, clock the DUT, compare, drop pulses.
    task automatic tick();
        bit          en[2];
        bit          ld[2];
        bit          rdv[2];
        bit          eow;
        bit          inb;
        bit          zhit;
        int unsigned pos_e;
        int unsigned shifted;
        en[0] = c2_en;
        en[1] = c3_en;
        ld[0] = load_c2;
        ld[1] = load_c3;
        pos_e = word_sync ? 0 : m_pos;
        eow   = bit_stb && !word_sync && (m_pos == W - 1);
        for (int x = 0; x < 2; x++) begin
            rdv[x] = 1'b0;
            zhit   = 1'b0;
            if (bit_stb) begin
                if (pos_e == 0) m_dec[x] = (m_val[x] - 1) & MASK;
                case (rd_mode[x])
                    0:       rdv[x] = (m_val[x] & 1) != 0;
                    1:       rdv[x] = ((m_dec[x] >> pos_e) & 1) != 0;
                    default: rdv[x] = ($urandom & 1) != 0;
                endcase
                inb       = (en[x] && m_run[x]) ? rdv[x] : ((m_val[x] & 1) != 0);
                shifted   = (m_val[x] >> 1) | (32'(inb) << (W - 1));
                m_ones[x] = ((pos_e == 0) ? 0 : m_ones[x]) + 32'(inb);
                if (eow && m_pend[x]) begin
                    m_val[x]  = m_hold[x];
                    m_run[x]  = 1'b1;
                    m_pend[x] = 1'b0;
                end else begin
                    m_val[x] = shifted;
                    if (eow && m_run[x] && en[x] && m_ones[x] == 0) begin
                        zhit     = 1'b1;
                        m_run[x] = 1'b0;
                    end
                end
            end
            if (ld[x]) begin
                m_hold[x] = 32'(load_data);
                m_pend[x] = 1'b1;
            end
            if (zhit) m_int[x] = 1'b1;
            else if (int_ack[x]) m_int[x] = 1'b0;
        end
        if (bit_stb) m_pos = word_sync ? 1 : ((m_pos == W - 1) ? 0 : m_pos + 1);
        c2rd = rdv[0];
        c3rd = rdv[1];
        @(posedge clk);
        #1;
        compare_outputs();
        load_c2   = 1'b0;
        load_c3   = 1'b0;
        word_sync = 1'b0;
        int_ack   = 2'b00;
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) begin
            bit_stb = 1'b1;
            tick();
        end
        bit_stb = 1'b0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before the next edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        compare_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        bit_stb   = 1'b0;
        word_sync = 1'b0;
        load_c2   = 1'b0;
        load_c3   = 1'b0;
        load_data = '0;
        c2_en     = 1'b0;
        c3_en     = 1'b0;
        c2rd      = 1'b0;
        c3rd      = 1'b0;
        int_ack   = 2'b00;
        rd_mode[0] = 0;
        rd_mode[1] = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Idle word after reset.
        strobes(26);
        check_val("t1_pos",  32'(bit_pos), 0);
        check_val("t1_c2rn", 32'(c2rn), 1);
        check_val("t1_c2r",  32'(c2r), 0);
        check_val("t1_int",  32'({int_c3, int_c2}), 0);

        // C2 load 5 with loopback.
        c2_en = 1'b1;
        rd_mode[0] = 0;
        load_data = 26'h5;
        load_c2 = 1'b1;
        bit_stb = 1'b1;
        tick();
        strobes(25);
        check_val("t2_val",  32'(c2_val), 32'h5);
        check_val("t2_bit0", 32'(c2r), 1);
        strobes(1);
        check_val("t2_bit1", 32'(c2r), 0);
        strobes(25);
        check_val("t2_val2", 32'(c2_val), 32'h5);

        // C3 counts 1 -> 0, interrupt set wins over simultaneous ack, then ack clears.
        c3_en = 1'b1;
        rd_mode[1] = 1;
        load_data = 26'h1;
        load_c3 = 1'b1;
        bit_stb = 1'b1;
        tick();
        strobes(25);
        check_val("t3_val1", 32'(c3_val), 32'h1);
        strobes(25);
        check_val("t3_noint", 32'(int_c3), 0);
        int_ack = 2'b10;
        bit_stb = 1'b1;
        tick();
        bit_stb = 1'b0;
        check_val("t5_setwins", 32'(int_c3), 1);
        check_val("t3_val0", 32'(c3_val), 0);
        int_ack = 2'b10;
        tick();
        check_val("t5_ack", 32'(int_c3), 0);
        strobes(26);
        check_val("t3_hold0", 32'(c3_val), 0);
        check_val("t3_stopped", 32'(int_c3), 0);

        // C2 reaches zero at the same strobe a load of 0 is applied: no interrupt, keeps running.
        rd_mode[0] = 1;
        load_data = 26'h1;
        load_c2 = 1'b1;
        bit_stb = 1'b1;
        tick();
        strobes(25);
        strobes(3);
        load_data = 26'h0;
        load_c2 = 1'b1;
        bit_stb = 1'b1;
        tick();
        strobes(22);
        check_val("t4_noint", 32'(int_c2), 0);
        check_val("t4_val", 32'(c2_val), 0);
        strobes(26);
        check_val("t4_runs", 32'(c2_val), 32'h3FFFFFF);
        check_val("t4_noint2", 32'(int_c2), 0);

        // Reset mid-word with INT_C2 set, then realign with WORD_SYNC.
        load_data = 26'h1;
        load_c2 = 1'b1;
        bit_stb = 1'b1;
        tick();
        strobes(25);
        strobes(26);
        check_val("t6_int", 32'(int_c2), 1);
        strobes(13);
        check_val("t6_pos13", 32'(bit_pos), 13);
        do_reset();
        check_val("t6_rst_int", 32'(int_c2), 0);
        check_val("t6_rst_pos", 32'(bit_pos), 0);
        check_val("t6_rst_c2rn", 32'(c2rn), 1);
        word_sync = 1'b1;
        bit_stb = 1'b1;
        tick();
        bit_stb = 1'b0;
        check_val("t6_sync", 32'(bit_pos), 1);

        // Random traffic.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 199) == 0) rd_mode[0] = $urandom_range(0, 2);
            if ($urandom_range(0, 199) == 0) rd_mode[1] = $urandom_range(0, 2);
            if ($urandom_range(0, 49) == 0) c2_en = !c2_en;
            if ($urandom_range(0, 49) == 0) c3_en = !c3_en;
            bit_stb   = ($urandom_range(0, 3) != 0);
            word_sync = bit_stb && ($urandom_range(0, 63) == 0);
            load_c2   = ($urandom_range(0, 29) == 0);
            load_c3   = ($urandom_range(0, 29) == 0);
            load_data = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 4)) : W'($urandom);
            int_ack   = 2'($urandom_range(0, 3) & (($urandom_range(0, 9) == 0) ? 3 : 0));
            tick();
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
